// File: rtl/twiddle_mult_if.sv
// Handshake and data bundle for the complex twiddle multiplier.
// Carries the input sample/twiddle stream, the rotated output stream and the sticky flag.
// slave = multiplier side, master = producer/consumer side (testbench or surrounding datapath).
interface twiddle_mult_if #(
    parameter int DW = 16,
    parameter int WW = 16
);
    // Input stream: sample plus the twiddle for that sample
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_real;
    logic signed [DW-1:0] in_imag;
    logic signed [WW-1:0] W_real;
    logic signed [WW-1:0] W_imag;
    logic                 w_en;

    // Output stream: rotated sample tagged with its position in the 4-point frame
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] out_real;
    logic signed [DW-1:0] out_imag;
    logic [1:0]           out_idx;

    // Sticky clamp indicator
    logic                 sat_flag;

    modport slave (
        input  in_valid,
        input  in_real,
        input  in_imag,
        input  W_real,
        input  W_imag,
        input  w_en,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_real,
        output out_imag,
        output out_idx,
        output sat_flag
    );

    modport master (
        output in_valid,
        output in_real,
        output in_imag,
        output W_real,
        output W_imag,
        output w_en,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_real,
        input  out_imag,
        input  out_idx,
        input  sat_flag
    );
endinterface

// File: rtl/twiddle_mult.sv
// Complex sample x Q1.14 twiddle rotation with round-half-up and saturation to DW bits.
// Latency: 3 cycles (operand reg, partial-product reg, rounded/saturated output reg).
// Backpressure: one global enable (!out_valid || out_ready) freezes every stage; in_ready mirrors it.
module twiddle_mult #(
    parameter int DW = 16,
    parameter int WW = 16
) (
    input  logic           clk,
    input  logic           rst,
    twiddle_mult_if.slave  bus
);
    // Product and sum widths: full precision, nothing truncated before rounding
    localparam int PW   = DW + WW;
    localparam int SW   = PW + 1;
    localparam int FRAC = WW - 2;

    // 1.0 in Q1.14 used when the twiddle is bypassed
    localparam logic signed [WW-1:0] W_ONE = {{(WW-FRAC-1){1'b0}}, 1'b1, {FRAC{1'b0}}};
    // Half an LSB of the output, added before the arithmetic shift
    localparam logic signed [SW-1:0] RND   = {{(SW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
    // Output range limits expressed at sum width
    localparam logic signed [SW-1:0] MAXV  = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [SW-1:0] MINV  = ~MAXV;

    // ------------------------------------------------------------------
    // Flow control
    // ------------------------------------------------------------------
    logic en;
    logic in_fire;
    logic out_vld_q;

    assign en           = !out_vld_q || bus.out_ready;
    assign in_fire      = bus.in_valid && en;
    assign bus.in_ready = en;

    // ------------------------------------------------------------------
    // Frame counter: position of each accepted sample in the 4-point frame
    // ------------------------------------------------------------------
    logic [1:0] cnt_q;
    logic [1:0] cnt_d;

    // Advance only on real transfers; bubbles leave the count alone
    always_comb begin
        cnt_d = cnt_q;
        if (in_fire) begin
            cnt_d = cnt_q + 2'd1;
        end
    end

    // Frame counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 2'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // S1: operand capture
    // ------------------------------------------------------------------
    logic                 s1_vld_q;
    logic signed [DW-1:0] s1_re_q;
    logic signed [DW-1:0] s1_im_q;
    logic signed [WW-1:0] s1_wr_q;
    logic signed [WW-1:0] s1_wi_q;
    logic [1:0]           s1_idx_q;
    logic signed [WW-1:0] s1_wr_d;
    logic signed [WW-1:0] s1_wi_d;

    // Bypass replaces the twiddle with exactly 1.0 + 0j so the same datapath is reused
    always_comb begin
        s1_wr_d = W_ONE;
        s1_wi_d = '0;
        if (bus.w_en) begin
            s1_wr_d = bus.W_real;
            s1_wi_d = bus.W_imag;
        end
    end

    // S1 valid bit
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q <= 1'b0;
        end else if (en) begin
            s1_vld_q <= bus.in_valid;
        end
    end

    // S1 data; meaningless while s1_vld_q is low, so no reset
    always_ff @(posedge clk) begin
        if (en) begin
            s1_re_q  <= bus.in_real;
            s1_im_q  <= bus.in_imag;
            s1_wr_q  <= s1_wr_d;
            s1_wi_q  <= s1_wi_d;
            s1_idx_q <= cnt_q;
        end
    end

    // ------------------------------------------------------------------
    // S2: four partial products at full precision
    // ------------------------------------------------------------------
    logic                 s2_vld_q;
    logic signed [PW-1:0] p_rr_q;
    logic signed [PW-1:0] p_ii_q;
    logic signed [PW-1:0] p_ri_q;
    logic signed [PW-1:0] p_ir_q;
    logic [1:0]           s2_idx_q;
    logic signed [PW-1:0] p_rr_d;
    logic signed [PW-1:0] p_ii_d;
    logic signed [PW-1:0] p_ri_d;
    logic signed [PW-1:0] p_ir_d;

    // Operands sign-extended to product width before multiplying
    always_comb begin
        p_rr_d = PW'(s1_re_q) * PW'(s1_wr_q);
        p_ii_d = PW'(s1_im_q) * PW'(s1_wi_q);
        p_ri_d = PW'(s1_re_q) * PW'(s1_wi_q);
        p_ir_d = PW'(s1_im_q) * PW'(s1_wr_q);
    end

    // S2 valid bit
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_vld_q <= 1'b0;
        end else if (en) begin
            s2_vld_q <= s1_vld_q;
        end
    end

    // S2 products; qualified by s2_vld_q
    always_ff @(posedge clk) begin
        if (en) begin
            p_rr_q   <= p_rr_d;
            p_ii_q   <= p_ii_d;
            p_ri_q   <= p_ri_d;
            p_ir_q   <= p_ir_d;
            s2_idx_q <= s1_idx_q;
        end
    end

    // ------------------------------------------------------------------
    // S3: combine, round, saturate, register as the output
    // ------------------------------------------------------------------
    logic signed [SW-1:0] sum_re;
    logic signed [SW-1:0] sum_im;
    logic signed [SW-1:0] sh_re;
    logic signed [SW-1:0] sh_im;
    logic signed [DW-1:0] res_re_d;
    logic signed [DW-1:0] res_im_d;
    logic                 clip_re;
    logic                 clip_im;

    // Complex combine at one extra bit, then round half toward +inf via add-half and floor shift
    always_comb begin
        sum_re = SW'(p_rr_q) - SW'(p_ii_q);
        sum_im = SW'(p_ri_q) + SW'(p_ir_q);
        sh_re  = (sum_re + RND) >>> FRAC;
        sh_im  = (sum_im + RND) >>> FRAC;
    end

    // Clamp each component to the signed DW-bit range and note whether it clipped
    always_comb begin
        res_re_d = sh_re[DW-1:0];
        clip_re  = 1'b0;
        if (sh_re > MAXV) begin
            res_re_d = MAXV[DW-1:0];
            clip_re  = 1'b1;
        end else if (sh_re < MINV) begin
            res_re_d = MINV[DW-1:0];
            clip_re  = 1'b1;
        end

        res_im_d = sh_im[DW-1:0];
        clip_im  = 1'b0;
        if (sh_im > MAXV) begin
            res_im_d = MAXV[DW-1:0];
            clip_im  = 1'b1;
        end else if (sh_im < MINV) begin
            res_im_d = MINV[DW-1:0];
            clip_im  = 1'b1;
        end
    end

    logic signed [DW-1:0] out_re_q;
    logic signed [DW-1:0] out_im_q;
    logic [1:0]           out_idx_q;
    logic                 sat_q;

    // Output register; data only reloads for a valid result so bubbles leave it steady
    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld_q <= 1'b0;
            out_re_q  <= '0;
            out_im_q  <= '0;
            out_idx_q <= 2'd0;
        end else if (en) begin
            out_vld_q <= s2_vld_q;
            if (s2_vld_q) begin
                out_re_q  <= res_re_d;
                out_im_q  <= res_im_d;
                out_idx_q <= s2_idx_q;
            end
        end
    end

    // Sticky saturation flag, set only by clipped results that actually advance
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_q <= 1'b0;
        end else if (en && s2_vld_q && (clip_re || clip_im)) begin
            sat_q <= 1'b1;
        end
    end

    assign bus.out_valid = out_vld_q;
    assign bus.out_real  = out_re_q;
    assign bus.out_imag  = out_im_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.sat_flag  = sat_q;

endmodule

// File: tb/tb_twiddle_mult.sv
// Directed bench for twiddle_mult: hand-computed vectors for rotation, bypass,
// rounding, saturation, backpressure and mid-stream reset.
// Outputs are sampled 1 time unit after the rising edge; transfers logged on the falling edge.
module tb_twiddle_mult;
    localparam int DW = 16;
    localparam int WW = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    twiddle_mult_if #(.DW(DW), .WW(WW)) bus ();

    twiddle_mult #(.DW(DW), .WW(WW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int q_re[$];
    int q_im[$];
    int q_idx[$];

    // Log every output transfer (values are stable mid-cycle)
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            q_re.push_back(int'(bus.out_real));
            q_im.push_back(int'(bus.out_imag));
            q_idx.push_back(int'(bus.out_idx));
        end
    end

    task automatic chk(input string tag, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int re, input int im, input int wr, input int wi, input bit wen);
        bus.in_valid = 1'b1;
        bus.in_real  = DW'(re);
        bus.in_imag  = DW'(im);
        bus.W_real   = WW'(wr);
        bus.W_imag   = WW'(wi);
        bus.w_en     = wen;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_vld(input string tag);
        int n;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            tick();
            n++;
        end
        if (!bus.out_valid) chk({tag, "_timeout"}, 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int k;
        int cyc;
        int n;
        bit acc;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_real   = '0;
        bus.in_imag   = '0;
        bus.W_real    = '0;
        bus.W_imag    = '0;
        bus.w_en      = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        tick();

        // Reset state
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_sat",       int'(bus.sat_flag), 0);
        chk("rst_out_real",  int'(bus.out_real), 0);
        chk("rst_out_idx",   int'(bus.out_idx), 0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready",  int'(bus.in_ready), 1);

        // Rotation by -j: (1000+500j)(-j) = 500-1000j
        drive(1000, 500, 0, -16384, 1'b1);
        tick();
        idle();
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("rot_latency", lat, 3);
        chk("rot_re",  int'(bus.out_real), 500);
        chk("rot_im",  int'(bus.out_imag), -1000);
        chk("rot_idx", int'(bus.out_idx), 0);
        tick();

        // Bypass ignores W
        drive(-1234, 777, 123, 456, 1'b0);
        tick();
        idle();
        wait_vld("byp");
        chk("byp_re",  int'(bus.out_real), -1234);
        chk("byp_im",  int'(bus.out_imag), 777);
        chk("byp_idx", int'(bus.out_idx), 1);
        chk("byp_sat", int'(bus.sat_flag), 0);
        tick();

        // Rounding: 3*0.5 = 1.5 -> 2, -3*0.5 = -1.5 -> -1 (back to back)
        drive(3, 0, 8192, 0, 1'b1);
        tick();
        drive(-3, 0, 8192, 0, 1'b1);
        tick();
        idle();
        wait_vld("rnd_pos");
        chk("rnd_pos_re",  int'(bus.out_real), 2);
        chk("rnd_pos_im",  int'(bus.out_imag), 0);
        chk("rnd_pos_idx", int'(bus.out_idx), 2);
        tick();
        wait_vld("rnd_neg");
        chk("rnd_neg_re",  int'(bus.out_real), -1);
        chk("rnd_neg_im",  int'(bus.out_imag), 0);
        chk("rnd_neg_idx", int'(bus.out_idx), 3);
        tick();

        // Saturation: (-32768-32768j)*(-1) = 32768+32768j -> clamp
        drive(-32768, -32768, -16384, 0, 1'b1);
        tick();
        idle();
        wait_vld("sat");
        chk("sat_re",   int'(bus.out_real), 32767);
        chk("sat_im",   int'(bus.out_imag), 32767);
        chk("sat_idx",  int'(bus.out_idx), 0);
        chk("sat_flag", int'(bus.sat_flag), 1);
        tick();

        // Clean sample afterwards; flag stays set
        drive(100, 0, 16384, 0, 1'b1);
        tick();
        idle();
        wait_vld("clean");
        chk("clean_re",   int'(bus.out_real), 100);
        chk("clean_im",   int'(bus.out_imag), 0);
        chk("clean_idx",  int'(bus.out_idx), 1);
        chk("clean_sat",  int'(bus.sat_flag), 1);
        tick();

        // Reset with two samples in flight
        drive(10, 20, 16384, 0, 1'b1);
        tick();
        drive(30, 40, 16384, 0, 1'b1);
        tick();
        idle();
        rst = 1'b1;
        tick();
        chk("rms_out_valid", int'(bus.out_valid), 0);
        chk("rms_sat",       int'(bus.sat_flag), 0);
        rst = 1'b0;
        #1;
        chk("rms_in_ready",  int'(bus.in_ready), 1);
        for (int i = 0; i < 4; i++) tick();
        chk("rms_flushed",   int'(bus.out_valid), 0);
        drive(7, 8, 16384, 0, 1'b1);
        tick();
        idle();
        wait_vld("rms_next");
        chk("rms_next_re",  int'(bus.out_real), 7);
        chk("rms_next_im",  int'(bus.out_imag), 8);
        chk("rms_next_idx", int'(bus.out_idx), 0);
        tick();

        // Backpressure: 8 samples rotated by +j, out_ready low in cycles 4-6
        rst = 1'b1;
        tick();
        rst = 1'b0;
        q_re.delete();
        q_im.delete();
        q_idx.delete();
        k   = 0;
        cyc = 0;
        while (k < 8 && cyc < 60) begin
            drive(100 * (k + 1), -50 * (k + 1), 0, 16384, 1'b1);
            bus.out_ready = !(cyc >= 4 && cyc <= 6);
            #1;
            if (cyc >= 4 && cyc <= 6) begin
                chk("bp_hold_vld", int'(bus.out_valid), 1);
                chk("bp_hold_re",  int'(bus.out_real), 100);
                chk("bp_hold_im",  int'(bus.out_imag), 200);
                chk("bp_hold_idx", int'(bus.out_idx), 1);
                chk("bp_in_ready", int'(bus.in_ready), 0);
            end
            acc = bus.in_ready;
            tick();
            if (acc) k++;
            cyc++;
        end
        idle();
        bus.out_ready = 1'b1;
        n = 0;
        while (q_re.size() < 8 && n < 30) begin
            tick();
            n++;
        end
        tick();
        chk("bp_count", q_re.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < q_re.size()) begin
                chk($sformatf("bp_re[%0d]", i),  q_re[i],  50 * (i + 1));
                chk($sformatf("bp_im[%0d]", i),  q_im[i],  100 * (i + 1));
                chk($sformatf("bp_idx[%0d]", i), q_idx[i], i % 4);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/twiddle_mult.md
TWIDDLE_MULT -- requirements
Module: twiddle_mult

Interface
REQ-001 Parameters: DW, default 16, data sample width, signed two's complement. WW, default 16, twiddle width, signed Q1.14.
REQ-002 Ports: clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 Ports: rst  input  1  reset; synchronous and active-high.
REQ-004 Ports: in_valid  input  1  input sample and twiddle present this cycle.
REQ-005 Ports: in_ready  output  1  block accepts the input this cycle.
REQ-006 Ports: in_real, in_imag  input  DW  complex input sample.
REQ-007 Ports: W_real, W_imag  input  WW  twiddle factor, same cycle as the sample, from the twiddle generator.
REQ-008 Ports: w_en  input  1  1 = rotate by W; 0 = bypass (multiply by 1.0); qualifies W.
REQ-009 Ports: out_valid  output  1  result present.
REQ-010 Ports: out_ready  input  1  downstream accepts the result.
REQ-011 Ports: out_real, out_imag  output  DW  rotated sample.
REQ-012 Ports: out_idx  output  2  sample index within the 4-point frame.
REQ-013 Ports: sat_flag  output  1  sticky saturation indicator.

Function
REQ-014 A transfer SHALL occur on any edge where in_valid and in_ready are both 1; out_valid and out_ready define output transfers the same way.
REQ-015 The block SHALL be a 3-stage pipeline. S1 registers the operands, S2 registers the four partial products, S3 registers the rounded and saturated result. Latency is exactly 3 cycles from input transfer to out_valid when no stall occurs.
REQ-016 Global stall enable en = !out_valid || out_ready; all stages and their valid bits SHALL advance only when en = 1; in_ready = en (combinational).
REQ-017 When en = 0, every stage register and the output SHALL hold unchanged; no sample is dropped or duplicated.
REQ-018 When w_en = 0 at input transfer, S1 SHALL substitute W_real = 16384 and W_imag = 0; W inputs are then ignored.
REQ-019 Real part: in_real*W_real - in_imag*W_imag. Imag part: in_real*W_imag + in_imag*W_real. Products are full 2*DW precision; sums are 2*DW+1 bits; no intermediate truncation.
REQ-020 Rounding: add 2^13, then arithmetic right shift by 14 (round half toward +infinity). Example: 1.5 -> 2, -1.5 -> -1.
REQ-021 Saturation: clamp the shifted result to [-2^(DW-1), 2^(DW-1)-1].
REQ-022 sat_flag SHALL set when any S3 result that advances is clamped; it stays set until rst.
REQ-023 A 2-bit frame counter SHALL increment on each input transfer, wrapping 3 -> 0. It travels with its sample as out_idx; the first sample after reset has index 0.
REQ-024 Bubbles (in_valid = 0 while en = 1) SHALL propagate as valid = 0 and SHALL NOT advance the frame counter.
REQ-025 Simultaneous output transfer and input transfer in one cycle SHALL be supported at full throughput (1 sample per cycle).

Reset
REQ-026 On rst = 1 at an edge: all stage valid bits and out_valid -> 0; out_real, out_imag, out_idx -> 0; frame counter -> 0; sat_flag -> 0.
REQ-027 rst SHALL take priority over stall and transfer; samples in flight are discarded; in_ready = 1 in the cycle after reset.
REQ-028 Data registers other than the outputs need no reset value; the valid bits alone define their meaning.

Verification
REQ-029 Rotation: in = (1000, 500), W = (0, -16384), w_en = 1 -> out (500, -1000) three cycles later, out_idx = 0.
REQ-030 Bypass: in = (-1234, 777), w_en = 0, W = (123, 456) -> out (-1234, 777); sat_flag stays 0.
REQ-031 Rounding: in = (3, 0) and then (-3, 0), W = (8192, 0) -> out_real 2 and then -1; out_imag 0 both.
REQ-032 Saturation: in = (-32768, -32768), W = (-16384, 0) -> out (32767, 32767); sat_flag = 1 and stays 1 after subsequent clean samples.
REQ-033 Backpressure: stream 8 samples with out_ready low for cycles 4-6 -> all 8 results emerge in order, none lost. out_idx sequence is 0,1,2,3,0,1,2,3. Outputs hold steady while stalled.
REQ-034 Reset mid-stream: assert rst with 2 samples in flight -> next edge out_valid = 0 and sat_flag = 0; the next accepted sample reports out_idx = 0.
